// File: rtl/clear_lines.sv
// Line-clear stage: scans the 10x24 board bottom-up, drops full rows, compacts
// the rest downward and zero-fills the vacated top rows through one RAM port.
module clear_lines (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [5:0] ram_q,
  output logic [7:0] ram_addr,
  output logic       wren,
  output logic [5:0] data,
  output logic       complete,
  output logic [4:0] lines_cleared
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_WAIT, RD_CAP, EVAL, WRITE, FILL, DONE
  } state_t;

  // Handshake: enable is a level; complete stays high from pass end until
  // enable drops, and enable low at any edge returns the stage to IDLE.
  state_t      state_q, state_d;
  logic [4:0]  src_q, src_d;
  logic [5:0]  dst_q, dst_d;
  logic [3:0]  col_q, col_d;
  logic [5:0]  row_buf_q [0:9];
  logic [5:0]  row_buf_d [0:9];
  logic        full_q, full_d;
  logic [4:0]  lines_q, lines_d;
  logic [7:0]  fill_q, fill_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic        wren_q, wren_d;
  logic [5:0]  data_q, data_d;
  logic        complete_q, complete_d;
  logic        advance;
  logic [5:0]  dst_n;

  function automatic logic [7:0] times10(input logic [4:0] r);
    return ({3'b000, r} << 3) + ({3'b000, r} << 1);
  endfunction

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    col_d      = col_q;
    row_buf_d  = row_buf_q;
    full_d     = full_q;
    lines_d    = lines_q;
    fill_d     = fill_q;
    ram_addr_d = ram_addr_q;
    wren_d     = 1'b0;
    data_d     = data_q;
    advance    = 1'b0;
    dst_n      = dst_q;

    case (state_q)
      IDLE: begin
        ram_addr_d = 8'd0;
        if (enable) begin
          src_d   = 5'd23;
          dst_d   = 6'd23;
          col_d   = 4'd0;
          full_d  = 1'b1;
          lines_d = 5'd0;
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        ram_addr_d = times10(src_q) + {4'b0000, col_q};
        state_d    = RD_WAIT;
      end
      RD_WAIT: state_d = RD_CAP;
      RD_CAP: begin
        row_buf_d[col_q] = ram_q;
        if (ram_q == 6'd0) full_d = 1'b0;
        if (col_q == 4'd9) begin
          state_d = EVAL;
        end else begin
          col_d   = col_q + 4'd1;
          state_d = RD_ADDR;
        end
      end
      EVAL: begin
        advance = 1'b1;
        if (full_q) begin
          lines_d = lines_q + 5'd1;
        end else if (dst_q != {1'b0, src_q}) begin
          col_d   = 4'd0;
          state_d = WRITE;
          advance = 1'b0;
        end else begin
          dst_n = dst_q - 6'd1;
        end
      end
      WRITE: begin
        ram_addr_d = times10(dst_q[4:0]) + {4'b0000, col_q};
        data_d     = row_buf_q[col_q];
        wren_d     = 1'b1;
        if (col_q == 4'd9) begin
          dst_n   = dst_q - 6'd1;
          advance = 1'b1;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      FILL: begin
        ram_addr_d = fill_q;
        data_d     = 6'd0;
        wren_d     = 1'b1;
        if (fill_q == 8'd0) state_d = DONE;
        else                fill_d  = fill_q - 8'd1;
      end
      DONE: ram_addr_d = 8'd0;
      default: state_d = IDLE;
    endcase

    // Row finished: either move up to the next source row or, at the top,
    // zero-fill whatever rows dst still points at (dst bit 5 = underflow).
    if (advance) begin
      dst_d = dst_n;
      if (src_q == 5'd0) begin
        if (!dst_n[5]) begin
          fill_d  = times10(dst_n[4:0]) + 8'd9;
          state_d = FILL;
        end else begin
          state_d = DONE;
        end
      end else begin
        src_d   = src_q - 5'd1;
        col_d   = 4'd0;
        full_d  = 1'b1;
        state_d = RD_ADDR;
      end
    end

    if (!enable) begin
      state_d    = IDLE;
      ram_addr_d = 8'd0;
      wren_d     = 1'b0;
    end

    complete_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      src_q      <= 5'd0;
      dst_q      <= 6'd0;
      col_q      <= 4'd0;
      for (int i = 0; i < 10; i++) row_buf_q[i] <= 6'd0;
      full_q     <= 1'b0;
      lines_q    <= 5'd0;
      fill_q     <= 8'd0;
      ram_addr_q <= 8'd0;
      wren_q     <= 1'b0;
      data_q     <= 6'd0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      col_q      <= col_d;
      row_buf_q  <= row_buf_d;
      full_q     <= full_d;
      lines_q    <= lines_d;
      fill_q     <= fill_d;
      ram_addr_q <= ram_addr_d;
      wren_q     <= wren_d;
      data_q     <= data_d;
      complete_q <= complete_d;
    end
  end

  assign ram_addr      = ram_addr_q;
  assign wren          = wren_q;
  assign data          = data_q;
  assign complete      = complete_q;
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_clear_lines.sv
// Directed bench for clear_lines: board RAM model with 2-edge read latency,
// hand-built boards and expected boards, write counting and handshake checks.
module tb_clear_lines;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic [5:0] ram_q;
  logic [7:0] ram_addr;
  logic       wren;
  logic [5:0] data;
  logic       complete;
  logic [4:0] lines_cleared;

  clear_lines dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .ram_q         (ram_q),
    .ram_addr      (ram_addr),
    .wren          (wren),
    .data          (data),
    .complete      (complete),
    .lines_cleared (lines_cleared)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- board RAM model ----------------
  logic [5:0] mem       [240];
  logic [5:0] init_mem  [240];
  logic [5:0] exp_board [240];
  logic       load;
  int         wr_cnt;
  int         bad_addr;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 240; i++) mem[i] <= init_mem[i];
      wr_cnt   <= 0;
      bad_addr <= 0;
    end else if (wren) begin
      if (ram_addr < 8'd240) mem[ram_addr] <= data;
      else                   bad_addr <= bad_addr + 1;
      wr_cnt <= wr_cnt + 1;
    end
    ram_q <= (ram_addr < 8'd240) ? mem[ram_addr] : 6'd0;
  end

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_board(input string tag);
    int bad;
    logic [5:0] e;
    exp_q.delete();
    for (int i = 0; i < 240; i++) exp_q.push_back(exp_board[i]);
    bad = 0;
    for (int i = 0; i < 240; i++) begin
      e = exp_q.pop_front();
      if (mem[i] !== e) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_boards();
    for (int i = 0; i < 240; i++) begin
      init_mem[i]  = 6'd0;
      exp_board[i] = 6'd0;
    end
  endtask

  task automatic put(input int r, input int c, input logic [5:0] v);
    init_mem[r*10 + c] = v;
  endtask

  task automatic want(input int r, input int c, input logic [5:0] v);
    exp_board[r*10 + c] = v;
  endtask

  task automatic load_board();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Starts at a negedge; returns cycles from IDLE exit to DONE entry (-1 on timeout).
  task automatic run_pass(input string tag, output int lat);
    int cnt;
    enable = 1'b1;
    cnt = 0;
    lat = -1;
    while (!complete && cnt < 3000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq({tag, "_complete"}, complete, 1);
    if (complete) lat = cnt - 1;
    repeat (3) @(negedge clk);
    check_eq({tag, "_complete_hold"}, complete, 1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_complete_fall"}, complete, 0);
    @(negedge clk);
  endtask

  function automatic logic [5:0] pat_a(input int c); return (c == 9) ? 6'd0 : 6'(c + 1);  endfunction
  function automatic logic [5:0] pat_b(input int c); return (c == 0) ? 6'd0 : 6'(c + 10); endfunction
  function automatic logic [5:0] pat_c(input int c); return (c == 5) ? 6'd0 : 6'(c + 20); endfunction
  function automatic logic [5:0] pat_d(input int c); return (c == 0) ? 6'd0 : 6'(c + 40); endfunction

  task automatic setup_single();
    clear_boards();
    for (int c = 0; c < 10; c++) begin
      put(23, c, 6'd5);
      put(22, c, pat_a(c));
      want(23, c, pat_a(c));
    end
  endtask

  task automatic setup_alt();
    clear_boards();
    for (int c = 0; c < 10; c++) begin
      put(23, c, 6'd7); put(22, c, pat_a(c));
      put(21, c, 6'd8); put(20, c, pat_b(c));
      put(19, c, 6'd9); put(18, c, pat_c(c));
      put(17, c, 6'd3); put(16, c, pat_d(c));
      want(23, c, pat_a(c)); want(22, c, pat_b(c));
      want(21, c, pat_c(c)); want(20, c, pat_d(c));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int cnt;
    resetn = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    clear_boards();
    repeat (3) @(negedge clk);
    check_eq("rst_ram_addr", ram_addr, 0);
    check_eq("rst_wren", wren, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_complete", complete, 0);
    check_eq("rst_lines", lines_cleared, 0);
    resetn = 1'b1;

    // Empty board: no writes, 744-cycle pass.
    clear_boards();
    load_board();
    run_pass("empty", lat);
    check_eq("empty_latency", lat, 744);
    check_eq("empty_lines", lines_cleared, 0);
    check_eq("empty_writes", wr_cnt, 0);
    check_board("empty_board");

    // Row 23 full, row 22 partial: 23 row copies plus one fill row.
    setup_single();
    load_board();
    run_pass("single", lat);
    check_eq("single_lines", lines_cleared, 1);
    check_eq("single_writes", wr_cnt, 240);
    check_board("single_board");

    // Rows 20..23 full, row 19 mixed.
    clear_boards();
    for (int r = 20; r < 24; r++)
      for (int c = 0; c < 10; c++) put(r, c, 6'(r + c + 1));
    for (int c = 0; c < 10; c++) begin
      put(19, c, (c % 3 == 0) ? 6'd0 : 6'(c + 20));
      want(23, c, (c % 3 == 0) ? 6'd0 : 6'(c + 20));
    end
    load_board();
    run_pass("four", lat);
    check_eq("four_lines", lines_cleared, 4);
    check_eq("four_writes", wr_cnt, 240);
    check_board("four_board");

    // Alternating full / partial rows 23..16.
    setup_alt();
    load_board();
    run_pass("alt", lat);
    check_eq("alt_lines", lines_cleared, 4);
    check_eq("alt_writes", wr_cnt, 240);
    check_eq("alt_bad_addr", bad_addr, 0);
    check_board("alt_board");

    // Every cell occupied: all 24 rows cleared, whole board filled with zero.
    clear_boards();
    for (int i = 0; i < 240; i++) init_mem[i] = 6'((i % 63) + 1);
    load_board();
    run_pass("allfull", lat);
    check_eq("allfull_lines", lines_cleared, 24);
    check_eq("allfull_writes", wr_cnt, 240);
    check_eq("allfull_bad_addr", bad_addr, 0);
    check_board("allfull_board");

    // Abort during the first copy write.
    setup_alt();
    load_board();
    enable = 1'b1;
    cnt = 0;
    while (!wren && cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq("abort_wren_seen", wren, 1);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_wren", wren, 0);
    check_eq("abort_addr", ram_addr, 0);
    check_eq("abort_complete", complete, 0);
    check_eq("abort_lines_hold", lines_cleared, 1);
    @(negedge clk);

    // Reset while reading row 22 (lines_cleared already 1).
    setup_single();
    load_board();
    enable = 1'b1;
    repeat (50) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("rstmid_addr", ram_addr, 0);
    check_eq("rstmid_wren", wren, 0);
    check_eq("rstmid_lines", lines_cleared, 0);
    check_eq("rstmid_complete", complete, 0);
    enable = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    load_board();
    run_pass("after_rst", lat);
    check_eq("after_rst_lines", lines_cleared, 1);
    check_eq("after_rst_writes", wr_cnt, 240);
    check_board("after_rst_board");

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
